nand4_in_debounce: RTL

NAND4_IN_DEBOUNCE -- requirements
Module: nand4_in_debounce

---
 rtl/nand4_dbnc_pkg.sv | 10 +
 rtl/nand4_dbnc_sync.sv | 23 ++
 rtl/nand4_in_debounce.sv | 114 +++++++++++
 3 files changed

// File: rtl/nand4_dbnc_pkg.sv
// Shared constants and FSM state type for the nand4 input debouncer.
package nand4_dbnc_pkg;
    localparam int unsigned NCH            = 4;
    localparam int unsigned MAX_STABLE_CYC = 255;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } dbnc_state_t;
endpackage

// File: rtl/nand4_dbnc_sync.sv
// Reset-to-zero register chain bringing asynchronous inputs into the clk domain.
module nand4_dbnc_sync #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/nand4_in_debounce.sv
// Four-channel debouncer feeding a 4-input NAND, with a valid/ready change report.
// Define NAND4_DBNC_SYNC_EN for a two-flop synchronizer; otherwise a single stage is used.
module nand4_in_debounce
    import nand4_dbnc_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] raw_in,
    output logic           a,
    output logic           b,
    output logic           c,
    output logic           d,
    output logic           chg_valid,
    input  logic           chg_ready,
    output logic [NCH-1:0] chg_vec,
    output logic           chg_lost
);
`ifdef NAND4_DBNC_SYNC_EN
    localparam int unsigned SYNC_DEPTH = 2;
`else
    localparam int unsigned SYNC_DEPTH = 1;
`endif
    localparam int unsigned CW = $clog2(STABLE_CYC) + 1;
    localparam logic [CW-1:0] CYC = CW'(STABLE_CYC);

    if (STABLE_CYC < 1 || STABLE_CYC > MAX_STABLE_CYC) begin : g_bad_cyc
        $error("nand4_in_debounce: STABLE_CYC out of range");
    end

    logic [NCH-1:0] s;
    logic [NCH-1:0] cand;
    logic [NCH-1:0] stab;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    dbnc_state_t    state;
    logic           upd;
    logic [NCH-1:0] upd_vec;

    nand4_dbnc_sync #(
        .WIDTH (NCH),
        .DEPTH (SYNC_DEPTH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_in),
        .q     (s)
    );

    assign cnt_inc = cnt + CW'(1);

    // Acceptance decode, shared by the stable register and the change handshake.
    always_comb begin
        upd     = 1'b0;
        upd_vec = stab;
        case (state)
            STABLE: if (s != stab && STABLE_CYC == 1) begin
                upd     = 1'b1;
                upd_vec = s;
            end
            SETTLE: if (s != stab && s == cand && cnt_inc == CYC) begin
                upd     = 1'b1;
                upd_vec = cand;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STABLE;
            cand      <= '0;
            cnt       <= '0;
            stab      <= '0;
            chg_valid <= 1'b0;
            chg_vec   <= '0;
            chg_lost  <= 1'b0;
        end else begin
            case (state)
                STABLE: if (s != stab) begin
                    cand <= s;
                    cnt  <= CW'(1);
                    if (!upd) state <= SETTLE;
                end
                SETTLE: begin
                    if (s == stab) begin
                        state <= STABLE;
                    end else if (s == cand) begin
                        cnt <= cnt_inc;
                        if (upd) state <= STABLE;
                    end else begin
                        cand <= s;
                        cnt  <= CW'(1);
                    end
                end
                default: state <= STABLE;
            endcase

            if (upd) stab <= upd_vec;

            if (upd) begin
                chg_valid <= 1'b1;
                chg_vec   <= upd_vec;
                chg_lost  <= chg_valid && !chg_ready;
            end else begin
                chg_lost <= 1'b0;
                if (chg_valid && chg_ready) chg_valid <= 1'b0;
            end
        end
    end

    assign {a, b, c, d} = stab;
endmodule
